// File: rtl/nmi_rr_arbiter.sv
// nmi_rr_arbiter: round-robin share of one nmi slave port among NUM_MST requesters, with a per-transaction watchdog
module nmi_rr_arbiter #(
    parameter int          NUM_MST       = 2,
    parameter int          TIMEOUT_CYC   = 1024,
    parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NUM_MST-1:0]         m_valid_i,
    input  logic [NUM_MST*32-1:0]      m_addr_i,
    input  logic [NUM_MST*32-1:0]      m_wdata_i,
    input  logic [NUM_MST*4-1:0]       m_wstrb_i,
    output logic [NUM_MST-1:0]         m_ready_o,
    output logic [31:0]                m_rdata_o,
    output logic                       s_valid_o,
    output logic [31:0]                s_addr_o,
    output logic [31:0]                s_wdata_o,
    output logic [3:0]                 s_wstrb_o,
    input  logic                       s_ready_i,
    input  logic [31:0]                s_rdata_i,
    output logic [$clog2(NUM_MST)-1:0] grant_id_o,
    output logic                       timeout_o
);
    localparam int GW = $clog2(NUM_MST);
    localparam int WW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    logic [GW-1:0]  gnt, last_gnt, winner;
    logic [WW-1:0]  wd_cnt;
    logic           held, live, ack, expire, done;

    function automatic logic [GW-1:0] rot(input logic [GW-1:0] base, input int off);
        return GW'((int'(base) + 1 + off) % NUM_MST);
    endfunction

    // scan downward so the lowest offset from last_gnt+1 overwrites and wins
    always_comb begin
        winner = gnt;
        for (int i = NUM_MST - 1; i >= 0; i--)
            if (m_valid_i[rot(last_gnt, i)]) winner = rot(last_gnt, i);
    end

    always_comb begin
        held       = m_valid_i[gnt];
        live       = (state == BUSY) && held;
        ack        = live && s_ready_i;
        expire     = live && !s_ready_i && (TIMEOUT_CYC != 0) && (wd_cnt == WD_LAST);
        done       = ack || expire;
        s_valid_o  = live;
        s_addr_o   = live ? m_addr_i[32*int'(gnt) +: 32] : '0;
        s_wdata_o  = live ? m_wdata_i[32*int'(gnt) +: 32] : '0;
        s_wstrb_o  = live ? m_wstrb_i[4*int'(gnt) +: 4] : '0;
        m_ready_o  = done ? NUM_MST'(1) << gnt : '0;
        m_rdata_o  = ack ? s_rdata_i : expire ? TIMEOUT_RDATA : '0;
        timeout_o  = expire;
        grant_id_o = gnt;
    end

    // a requester that drops valid mid-transaction is abandoned without a ready pulse
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            gnt      <= '0;
            last_gnt <= GW'(NUM_MST - 1);
            wd_cnt   <= '0;
        end else if (state == IDLE) begin
            if (|m_valid_i) begin
                gnt    <= winner;
                state  <= BUSY;
                wd_cnt <= '0;
            end
        end else if (!held || done) begin
            last_gnt <= gnt;
            state    <= IDLE;
        end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_nmi_rr_arbiter.sv
// tb_nmi_rr_arbiter: scoreboarded bench; u0 is a 3-requester arbiter with an 8-cycle watchdog, u1 has the watchdog disabled
module tb_nmi_rr_arbiter;
    logic clk = 0, rst_n = 1;
    always #5 clk = ~clk;

    logic [2:0]  m_valid, m_ready;
    logic [95:0] m_addr, m_wdata;
    logic [11:0] m_wstrb;
    logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_valid, s_ready, tmo;
    logic [1:0]  gid;

    logic [1:0]  v1, r1;
    logic [63:0] a1, d1;
    logic [7:0]  w1;
    logic [31:0] rd1, sa1, sd1, srd1;
    logic [3:0]  sw1;
    logic        sv1, sr1, t1;
    logic [0:0]  g1;

    nmi_rr_arbiter #(.NUM_MST(3), .TIMEOUT_CYC(8)) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .m_valid_i(m_valid), .m_addr_i(m_addr),
        .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb), .m_ready_o(m_ready), .m_rdata_o(m_rdata),
        .s_valid_o(s_valid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
        .s_ready_i(s_ready), .s_rdata_i(s_rdata), .grant_id_o(gid), .timeout_o(tmo)
    );

    nmi_rr_arbiter #(.NUM_MST(2), .TIMEOUT_CYC(0)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .m_valid_i(v1), .m_addr_i(a1),
        .m_wdata_i(d1), .m_wstrb_i(w1), .m_ready_o(r1), .m_rdata_o(rd1),
        .s_valid_o(sv1), .s_addr_o(sa1), .s_wdata_o(sd1), .s_wstrb_o(sw1),
        .s_ready_i(sr1), .s_rdata_i(srd1), .grant_id_o(g1), .timeout_o(t1)
    );

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        tmo;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int total = 0, bad = 0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [31:0] rd, input logic t);
        exp_t e;
        e.id = id;
        e.rdata = rd;
        e.tmo = t;
        q.push_back(e);
    endtask

    task automatic apply_reset;
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    // every completion pulse of u0 is matched against the oldest expected completion
    always @(negedge clk) begin
        total++;
        if (m_ready != 0) begin
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected m_ready=%b rdata=%h expected none", m_ready, m_rdata);
            end else begin
                me = q.pop_front();
                if (m_ready !== 3'(1 << me.id) || m_rdata !== me.rdata || tmo !== me.tmo) begin
                    bad++;
                    $display("FAIL sb_completion m_ready=%b rdata=%h tmo=%b expected m_ready=%b rdata=%h tmo=%b",
                             m_ready, m_rdata, tmo, 3'(1 << me.id), me.rdata, me.tmo);
                end
            end
        end else if (m_rdata !== 0 || tmo !== 0) begin
            bad++;
            $display("FAIL idle_outputs rdata=%h tmo=%b expected 0 0", m_rdata, tmo);
        end
    end

    task automatic test_reset;
        #2 rst_n = 0;
        #4;
        total++;
        if ({s_valid, m_ready, gid, tmo, s_addr, s_wdata, s_wstrb, m_rdata} !== '0 || {sv1, r1, g1, t1} !== '0) begin
            bad++;
            $display("FAIL reset_outputs s_valid=%b m_ready=%b gid=%0d tmo=%b u1=%b expected all 0",
                     s_valid, m_ready, gid, tmo, {sv1, r1, g1, t1});
        end
        step();
        rst_n = 1;
    endtask

    task automatic test_single_read;
        m_valid = 3'b001;
        m_addr[31:0] = 32'h3000_0010;
        m_wstrb[3:0] = 4'h0;
        push(0, 32'h1234_5678, 0);
        @(negedge clk);
        total++;
        if (s_valid !== 1'b0) begin
            bad++;
            $display("FAIL read_latency s_valid=%b expected 0", s_valid);
        end
        @(negedge clk);
        total++;
        if (s_valid !== 1'b1 || s_addr !== 32'h3000_0010 || s_wstrb !== 4'h0 || gid !== 2'd0) begin
            bad++;
            $display("FAIL read_forward s_valid=%b addr=%h wstrb=%h gid=%0d expected 1 30000010 0 0",
                     s_valid, s_addr, s_wstrb, gid);
        end
        step();
        @(negedge clk);
        total++;
        if (m_ready !== 3'b000 || s_valid !== 1'b1) begin
            bad++;
            $display("FAIL read_wait m_ready=%b s_valid=%b expected 000 1", m_ready, s_valid);
        end
        step();
        s_ready = 1;
        s_rdata = 32'h1234_5678;
        step();
        m_valid = 0;
        s_ready = 0;
        s_rdata = 0;
        @(negedge clk);
        total++;
        if (s_valid !== 1'b0) begin
            bad++;
            $display("FAIL read_release s_valid=%b expected 0", s_valid);
        end
    endtask

    task automatic test_simultaneous;
        apply_reset();
        m_valid = 3'b011;
        m_addr[63:0]  = {32'h0000_0200, 32'h0000_0100};
        m_wdata[63:0] = {32'hBBBB_1111, 32'hAAAA_0000};
        m_wstrb[7:0]  = {4'h3, 4'hF};
        s_ready = 1;
        s_rdata = 32'h5555_0000;
        push(0, 32'h5555_0000, 0);
        push(1, 32'h5555_0000, 0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (gid !== 2'd0 || s_wstrb !== 4'hF || s_addr !== 32'h100 || s_wdata !== 32'hAAAA_0000) begin
            bad++;
            $display("FAIL simul_first gid=%0d wstrb=%h addr=%h wdata=%h expected 0 f 100 aaaa0000",
                     gid, s_wstrb, s_addr, s_wdata);
        end
        step();
        m_valid = 3'b010;
        @(negedge clk);
        total++;
        if (s_valid !== 1'b0 || gid !== 2'd0) begin
            bad++;
            $display("FAIL simul_gap s_valid=%b gid=%0d expected 0 0", s_valid, gid);
        end
        @(negedge clk);
        total++;
        if (gid !== 2'd1 || s_wstrb !== 4'h3 || s_addr !== 32'h200 || s_wdata !== 32'hBBBB_1111) begin
            bad++;
            $display("FAIL simul_second gid=%0d wstrb=%h addr=%h wdata=%h expected 1 3 200 bbbb1111",
                     gid, s_wstrb, s_addr, s_wdata);
        end
        step();
        m_valid = 0;
        s_ready = 0;
    endtask

    task automatic test_fairness;
        apply_reset();
        m_valid = 3'b111;
        s_ready = 1;
        s_rdata = 32'hC0DE_0000;
        for (int j = 0; j < 9; j++) push(j % 3, 32'hC0DE_0000, 0);
        repeat (18) step();
        m_valid = 0;
        s_ready = 0;
        repeat (2) step();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL fair_drain pending=%0d expected 0", q.size());
        end
    endtask

    task automatic test_watchdog;
        apply_reset();
        m_valid = 3'b001;
        s_ready = 0;
        push(0, 32'hDEAD_BEEF, 1);
        @(posedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            total++;
            if (i < 8 && (m_ready !== 3'b000 || tmo !== 1'b0 || s_valid !== 1'b1)) begin
                bad++;
                $display("FAIL wd_early cyc=%0d m_ready=%b tmo=%b s_valid=%b expected 000 0 1", i, m_ready, tmo, s_valid);
            end else if (i == 8 && (tmo !== 1'b1 || m_rdata !== 32'hDEAD_BEEF)) begin
                bad++;
                $display("FAIL wd_fire tmo=%b rdata=%h expected 1 deadbeef", tmo, m_rdata);
            end
        end
        step();
        m_valid = 0;
        s_ready = 1;
        s_rdata = 32'h1111_1111;
        @(negedge clk);
        total++;
        if (m_ready !== 3'b000 || tmo !== 1'b0 || s_valid !== 1'b0) begin
            bad++;
            $display("FAIL wd_late_ack m_ready=%b tmo=%b s_valid=%b expected 000 0 0", m_ready, tmo, s_valid);
        end
        step();
        s_ready = 0;
        s_rdata = 0;
    endtask

    task automatic test_reset_mid;
        m_valid = 3'b010;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (s_valid !== 1'b1 || gid !== 2'd1) begin
            bad++;
            $display("FAIL mid_busy s_valid=%b gid=%0d expected 1 1", s_valid, gid);
        end
        #2 rst_n = 0;
        #1;
        total++;
        if (s_valid !== 1'b0 || m_ready !== 3'b000 || gid !== 2'd0) begin
            bad++;
            $display("FAIL mid_async s_valid=%b m_ready=%b gid=%0d expected 0 000 0", s_valid, m_ready, gid);
        end
        step();
        step();
        rst_n = 1;
        m_valid = 3'b011;
        s_ready = 1;
        s_rdata = 32'h0BAD_F00D;
        push(0, 32'h0BAD_F00D, 0);
        @(posedge clk);
        @(negedge clk);
        total++;
        if (gid !== 2'd0 || s_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_tie gid=%0d s_valid=%b expected 0 1", gid, s_valid);
        end
        step();
        m_valid = 0;
        s_ready = 0;
    endtask

    task automatic test_abort;
        m_valid = 3'b001;
        @(posedge clk);
        @(negedge clk);
        #2 m_valid = 0;
        #1;
        total++;
        if (s_valid !== 1'b0 || m_ready !== 3'b000) begin
            bad++;
            $display("FAIL abort_drop s_valid=%b m_ready=%b expected 0 000", s_valid, m_ready);
        end
        step();
        @(negedge clk);
        total++;
        if (s_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle s_valid=%b expected 0", s_valid);
        end
    endtask

    task automatic test_no_watchdog;
        bit err = 0;
        v1 = 2'b01;
        a1[31:0] = 32'h4000_0000;
        @(posedge clk);
        repeat (5000) begin
            @(negedge clk);
            if (sv1 !== 1'b1 || t1 !== 1'b0 || r1 !== 2'b00) err = 1;
        end
        total++;
        if (err) begin
            bad++;
            $display("FAIL nowd_hold saw s_valid drop, timeout or ready before ack expected none");
        end
        step();
        sr1 = 1;
        srd1 = 32'hFEED_0001;
        @(negedge clk);
        total++;
        if (r1 !== 2'b01 || rd1 !== 32'hFEED_0001 || t1 !== 1'b0) begin
            bad++;
            $display("FAIL nowd_ack m_ready=%b rdata=%h tmo=%b expected 01 feed0001 0", r1, rd1, t1);
        end
        step();
        v1 = 0;
        sr1 = 0;
        srd1 = 0;
    endtask

    initial begin
        m_valid = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0; s_ready = 0; s_rdata = 0;
        v1 = 0; a1 = 0; d1 = 0; w1 = 0; sr1 = 0; srd1 = 0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_watchdog();
        test_reset_mid();
        test_abort();
        test_no_watchdog();
        repeat (2) step();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover pending=%0d expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nmi_rr_arbiter.md
Name: nmi_rr_arbiter

Overview:
- Shares one downstream nmi slave port (bus fabric toward flash/SRAM/peripherals) between NUM_MST upstream nmi requesters, e.g. several user cores or a core plus a DMA engine.
- Uses round-robin arbitration with a one-transaction grant lock.
- A per-transaction watchdog terminates any transaction the slave never acknowledges, so one stuck target cannot hang every requester.

Parameters:
- NUM_MST, 2: number of upstream requesters (2..8).
- TIMEOUT_CYC, 1024: maximum BUSY cycles without s_ready_i before forced completion; 0 disables the watchdog.
- TIMEOUT_RDATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- m_valid_i  in  NUM_MST  per-requester request.
- m_addr_i  in  NUM_MST*32  packed addresses; requester k occupies [32k+31:32k].
- m_wdata_i  in  NUM_MST*32  packed write data.
- m_wstrb_i  in  NUM_MST*4  packed byte strobes; 0 = read.
- m_ready_o  out  NUM_MST  one-cycle completion pulse to the granted requester.
- m_rdata_o  out  32  shared read data, meaningful only while a m_ready_o bit is high.
- s_valid_o  out  1  downstream request.
- s_addr_o  out  32  downstream address.
- s_wdata_o  out  32  downstream write data.
- s_wstrb_o  out  4  downstream strobes.
- s_ready_i  in  1  downstream completion.
- s_rdata_i  in  32  downstream read data.
- grant_id_o  out  $clog2(NUM_MST)  index of the current/last granted requester.
- timeout_o  out  1  one-cycle pulse on forced completion.

Behaviour:
- Protocol (both sides): a request is presented by valid with addr/wdata/wstrb stable and completes in the cycle valid && ready. Requesters hold valid until ready.
- State register: IDLE, BUSY. Registers: gnt, last_gnt, wd_cnt.
- Reset (async, rst_n_i=0):
  - state=IDLE, last_gnt=NUM_MST-1 so requester 0 wins first, gnt=0, wd_cnt=0.
  - All outputs 0.
- IDLE:
  - s_valid_o=0, m_ready_o=0, s_addr_o/s_wdata_o/s_wstrb_o=0.
  - If any m_valid_i bit is set, the winner is the first set bit searching from last_gnt+1 upward, modulo NUM_MST. Register it into gnt, go to BUSY, clear wd_cnt.
  - Arbitration latency is one cycle from m_valid_i to s_valid_o.
  - s_ready_i is ignored in IDLE (stray/late acks).
- BUSY:
  - s_valid_o=1. s_addr_o/s_wdata_o/s_wstrb_o are driven combinationally from requester gnt's slice.
  - No re-arbitration; the grant is locked for the whole transaction.
  - If s_ready_i=1: m_ready_o[gnt]=1 and m_rdata_o=s_rdata_i in the same cycle (zero added return latency). Then last_gnt<=gnt and state goes to IDLE.
  - Else if TIMEOUT_CYC!=0 and wd_cnt==TIMEOUT_CYC-1: m_ready_o[gnt]=1, m_rdata_o=TIMEOUT_RDATA, timeout_o=1. Then last_gnt<=gnt and state goes to IDLE. A write is silently dropped.
  - Else wd_cnt increments, saturating at its maximum.
  - If m_valid_i[gnt] falls while BUSY (protocol violation): s_valid_o drops that cycle, no m_ready_o, last_gnt<=gnt, state goes to IDLE.
- Completion always spends one IDLE cycle before the next grant, so the minimum per-transaction period is 2 cycles with a zero-wait slave.
- Fairness: a continuously requesting set of k masters is served in strict rotation. No requester waits more than NUM_MST-1 transactions.
- m_rdata_o=0 whenever no m_ready_o bit is set.
- grant_id_o=gnt at all times; it holds its value in IDLE.
- At most one m_ready_o bit is high in any cycle.
- Reset asserted mid-BUSY: immediate return to reset values; the in-flight transaction is abandoned with no m_ready_o.
- wd_cnt width: $clog2(TIMEOUT_CYC+1), minimum 1.

Test Plan:
- Single requester read: m_valid_i=2'b01, addr 0x3000_0010, slave acks after 3 cycles with rdata 0x1234_5678. Required: s_valid_o at cycle 1, s_addr_o=0x3000_0010, m_ready_o=2'b01 with m_rdata_o=0x1234_5678 on the ack cycle, grant_id_o=0.
- Simultaneous requests after reset: m_valid_i=2'b11 at cycle 0, zero-wait slave. Required: requester 0 served first, requester 1 granted 2 cycles later, writes forwarded with their own wstrb (0xF and 0x3).
- Fairness with NUM_MST=3: all three request continuously for 9 transactions. Required: grant order 0,1,2,0,1,2,0,1,2, and no more than one m_ready_o bit high in any cycle.
- Watchdog with TIMEOUT_CYC=8: slave never acks. Required: at BUSY cycle 8, m_ready_o pulses, m_rdata_o=0xDEAD_BEEF, timeout_o=1 for one cycle. A late s_ready_i arriving in IDLE is ignored.
- Reset mid-transaction: assert rst_n_i low during BUSY. Required: asynchronously s_valid_o=0, m_ready_o=0, grant_id_o=0. After release, requester 0 wins the next tie.
- Watchdog disabled (TIMEOUT_CYC=0): slave acks after 5000 cycles. Required: no timeout_o, normal completion with slave rdata.
